// File: rtl/reaction_timebase_pkg.sv
// -----------------------------------------------------------------------------
// reaction_pkg
// Shared definitions for the reaction-time game timing back-end.
//   - state_t       : timebase FSM state encoding
//   - LFSR_SEED     : reset value of the free-running random source
//   - LFSR_TAPS     : feedback tap mask for x^16+x^14+x^13+x^11+1
//   - lfsr_step()   : one shift of the LFSR
//   - width / default constants used by the top and the interface
// -----------------------------------------------------------------------------
package reaction_pkg;

    // state | meaning
    // ------+----------------------------------------------------------
    // IDLE  | nothing in progress, result (if any) still displayed
    // DELAY | random wait running, delay counter decremented per ms
    // EXPIRED | wait over, delay_done high, waiting for start_timer
    // RUN   | reaction counting, elapsed_time incremented per ms
    // HOLD  | counting stopped, elapsed_time frozen until next arm
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_EXPIRED = 3'd2,
        ST_RUN     = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam int ELAPSED_W = 14;
    localparam int DELAY_W   = 12;

    localparam int TICK_DIV_DEF     = 10000;
    localparam int MIN_DELAY_MS_DEF = 1000;
    localparam int RAND_BITS_DEF    = 11;
    localparam int MAX_COUNT_DEF    = 9999;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Right-shifting Fibonacci form: the polynomial taps 16,14,13,11 land
    // on bits 0,2,3,5 and the XOR of those bits is shifted in at bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/reaction_timebase_if.sv
// -----------------------------------------------------------------------------
// reaction_timebase_if
// Request/response signals between the game control FSM and the timebase.
//   master (control FSM) : drives arm, abort, start_timer, stop_timer
//                          observes delay_done, elapsed_time, running, overflow
//   slave  (timebase)    : the reverse directions
// -----------------------------------------------------------------------------
interface reaction_timebase_if;
    import reaction_pkg::*;

    logic                 arm;
    logic                 abort;
    logic                 start_timer;
    logic                 stop_timer;
    logic                 delay_done;
    logic [ELAPSED_W-1:0] elapsed_time;
    logic                 running;
    logic                 overflow;

    modport master (
        output arm,
        output abort,
        output start_timer,
        output stop_timer,
        input  delay_done,
        input  elapsed_time,
        input  running,
        input  overflow
    );

    modport slave (
        input  arm,
        input  abort,
        input  start_timer,
        input  stop_timer,
        output delay_done,
        output elapsed_time,
        output running,
        output overflow
    );

endinterface

// File: rtl/reaction_timebase_lfsr.sv
// -----------------------------------------------------------------------------
// reaction_lfsr16
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded with
// LFSR_SEED on reset and shifted on every clock regardless of game state.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   q     : current LFSR value
// -----------------------------------------------------------------------------
module reaction_lfsr16
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_step(lfsr_q);
    assign q      = lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/reaction_timebase.sv
// -----------------------------------------------------------------------------
// reaction_timebase
// Timing back-end for the reaction-time game. On arm it runs a pseudo-random
// wait (MIN_DELAY_MS + LFSR bits, in ms) and raises delay_done; on start_timer
// it counts reaction time in ms; on stop_timer it freezes the count.
//   clk   : system clock, shared with the control FSM
//   rst_n : asynchronous active-low reset
//   ctrl  : slave side of reaction_timebase_if
//             arm / abort / start_timer / stop_timer in
//             delay_done / elapsed_time / running / overflow out (registered)
// Parameters:
//   TICK_DIV     : clocks per 1 ms tick
//   MIN_DELAY_MS : fixed part of the random wait
//   RAND_BITS    : number of LFSR bits added to the wait
//   MAX_COUNT    : saturation value of elapsed_time
// MIN_DELAY_MS + 2**RAND_BITS - 1 must fit in the 12-bit delay counter.
// -----------------------------------------------------------------------------
module reaction_timebase
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
    parameter int RAND_BITS    = RAND_BITS_DEF,
    parameter int MAX_COUNT    = MAX_COUNT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    reaction_timebase_if.slave  ctrl
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [15:0]          RAND_MASK  = 16'((32'd1 << RAND_BITS) - 1);
    localparam logic [ELAPSED_W-1:0] COUNT_MAX  = ELAPSED_W'(MAX_COUNT);
    localparam logic [DELAY_W-1:0]   DELAY_MIN  = DELAY_W'(MIN_DELAY_MS);

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;
    logic                 overflow_q, overflow_d;
    logic                 delay_done_q;
    logic                 running_q;

    logic [15:0]          lfsr;
    logic [DELAY_W-1:0]   delay_load;
    logic                 timing_state;
    logic                 ms_tick;

    reaction_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr)
    );

    // Only this load samples the LFSR; the human timing of arm supplies
    // the randomness.
    assign delay_load = DELAY_MIN + DELAY_W'(lfsr & RAND_MASK);

    assign timing_state = (state_q == ST_DELAY) || (state_q == ST_RUN);
    assign ms_tick      = timing_state && (presc_q == PRESC_LAST);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        delay_d    = delay_q;
        elapsed_d  = elapsed_q;
        overflow_d = overflow_q;

        if (timing_state) begin
            presc_d = ms_tick ? '0 : presc_q + PRESC_W'(1);
        end

        if (ctrl.abort) begin
            state_d = ST_IDLE;
            delay_d = '0;
        end else if (ctrl.arm) begin
            state_d    = ST_DELAY;
            delay_d    = delay_load;
            elapsed_d  = '0;
            overflow_d = 1'b0;
            presc_d    = '0;
        end else begin
            case (state_q)
                ST_DELAY: begin
                    // Expiry is seen one cycle after the counter lands on 0,
                    // which gives the load*TICK_DIV + 1 latency to delay_done.
                    if (delay_q == '0) begin
                        state_d = ST_EXPIRED;
                    end else if (ms_tick) begin
                        delay_d = delay_q - DELAY_W'(1);
                    end
                end
                ST_EXPIRED: begin
                    if (ctrl.start_timer) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    // A tick coinciding with stop_timer is dropped.
                    if (ctrl.stop_timer) begin
                        state_d = ST_HOLD;
                    end else if (ms_tick) begin
                        if (elapsed_q == COUNT_MAX) begin
                            overflow_d = 1'b1;
                        end else begin
                            elapsed_d = elapsed_q + ELAPSED_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            delay_q      <= '0;
            elapsed_q    <= '0;
            overflow_q   <= 1'b0;
            delay_done_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            delay_q      <= delay_d;
            elapsed_q    <= elapsed_d;
            overflow_q   <= overflow_d;
            // Status flags are decoded from the next state so they are
            // registered yet aligned with the state they describe.
            delay_done_q <= (state_d == ST_EXPIRED);
            running_q    <= (state_d == ST_RUN);
        end
    end

    assign ctrl.delay_done   = delay_done_q;
    assign ctrl.elapsed_time = elapsed_q;
    assign ctrl.running      = running_q;
    assign ctrl.overflow     = overflow_q;

endmodule

// File: tb/tb_reaction_timebase.sv
module tb_reaction_timebase;

    localparam int TICK  = 4;
    localparam int MIND  = 3;
    localparam int RBITS = 2;
    localparam int MAXC  = 9;

    typedef enum int {M_IDLE, M_WAIT, M_READY, M_COUNT, M_FROZEN} mmode_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    reaction_timebase_if bus ();

    reaction_timebase #(
        .TICK_DIV     (TICK),
        .MIN_DELAY_MS (MIND),
        .RAND_BITS    (RBITS),
        .MAX_COUNT    (MAXC)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference LFSR written directly from the polynomial taps 16,14,13,11.
    function automatic logic [15:0] ref_lfsr_next(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    // Behavioural model: time-stamp based. Edges are numbered from reset;
    // the wait ends at a fixed edge index and the count is floor(edges/TICK).
    mmode_t      m_mode;
    int unsigned m_n, m_exp, m_t0, m_el;
    logic        m_ov;
    logic [15:0] m_lfsr;

    always @(posedge clk or negedge rst_n) begin : model
        mmode_t      md;
        int unsigned n, ea, t0, el, tk;
        logic        ov;
        if (!rst_n) begin
            m_mode <= M_IDLE;
            m_n    <= 0;
            m_exp  <= 0;
            m_t0   <= 0;
            m_el   <= 0;
            m_ov   <= 1'b0;
            m_lfsr <= 16'hACE1;
        end else begin
            md = m_mode; n = m_n + 1; ea = m_exp; t0 = m_t0; el = m_el; ov = m_ov;
            if (bus.abort) begin
                md = M_IDLE;
            end else if (bus.arm) begin
                md = M_WAIT;
                ea = n + (MIND + (int'(m_lfsr) % (1 << RBITS))) * TICK + 1;
                el = 0;
                ov = 1'b0;
            end else if (bus.stop_timer && md == M_COUNT) begin
                tk = (n - 1 - t0) / TICK;
                el = (tk > MAXC) ? MAXC : tk;
                ov = (tk > MAXC);
                md = M_FROZEN;
            end else if (bus.start_timer && md == M_READY) begin
                md = M_COUNT;
                t0 = n;
            end
            if (md == M_WAIT && n == ea) md = M_READY;
            if (md == M_COUNT) begin
                tk = (n - t0) / TICK;
                el = (tk > MAXC) ? MAXC : tk;
                ov = (tk > MAXC);
            end
            m_mode <= md;
            m_n    <= n;
            m_exp  <= ea;
            m_t0   <= t0;
            m_el   <= el;
            m_ov   <= ov;
            m_lfsr <= ref_lfsr_next(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("delay_done", int'(bus.delay_done), int'(m_mode == M_READY));
            check("running", int'(bus.running), int'(m_mode == M_COUNT));
            check("elapsed_time", int'(bus.elapsed_time), int'(m_el));
            check("overflow", int'(bus.overflow), int'(m_ov));
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!bus.delay_done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!bus.delay_done) check("delay_done_timeout", 0, 1);
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1; cyc(1); bus.arm = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_timer = 1'b1; cyc(1); bus.start_timer = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop_timer = 1'b1; cyc(1); bus.stop_timer = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int seen;
        bus.arm = 1'b0;
        bus.abort = 1'b0;
        bus.start_timer = 1'b0;
        bus.stop_timer = 1'b0;
        cyc(3);
        check("rst_delay_done", int'(bus.delay_done), 0);
        check("rst_running", int'(bus.running), 0);
        check("rst_elapsed", int'(bus.elapsed_time), 0);
        check("rst_overflow", int'(bus.overflow), 0);

        // arm on the first edge after reset: LFSR = ACE1, load 3+1 = 4
        rst_n = 1'b1;
        pulse_arm();
        wait_done(k);
        check("arm_to_done_cycles", k, 17);
        cyc(10);
        check("done_held", int'(bus.delay_done), 1);

        // start, stop 22 cycles later: ticks at +4..+20 -> 5
        pulse_start();
        check("done_fall_on_start", int'(bus.delay_done), 0);
        check("running_rise", int'(bus.running), 1);
        cyc(21);
        check("running_before_stop", int'(bus.running), 1);
        pulse_stop();
        check("elapsed_after_stop", int'(bus.elapsed_time), 5);
        check("running_fall", int'(bus.running), 0);
        cyc(50);
        check("elapsed_held", int'(bus.elapsed_time), 5);

        // abort mid-delay
        pulse_arm();
        cyc(5);
        bus.abort = 1'b1; cyc(1); bus.abort = 1'b0;
        seen = 0;
        repeat (40) begin
            cyc(1);
            if (bus.delay_done) seen = 1;
        end
        check("abort_no_done", seen, 0);
        check("abort_elapsed_cleared_by_arm", int'(bus.elapsed_time), 0);
        pulse_start();
        cyc(3);
        check("start_in_idle_ignored", int'(bus.running), 0);

        // saturation at MAX_COUNT = 9
        pulse_arm();
        wait_done(k);
        pulse_start();
        cyc(60);
        check("sat_elapsed", int'(bus.elapsed_time), 9);
        check("sat_overflow", int'(bus.overflow), 1);
        check("sat_still_running", int'(bus.running), 1);
        pulse_arm();
        check("arm_clears_elapsed", int'(bus.elapsed_time), 0);
        check("arm_clears_overflow", int'(bus.overflow), 0);

        // stop coincides with the 5th tick: only 4 counted
        wait_done(k);
        pulse_start();
        cyc(19);
        pulse_stop();
        check("stop_on_tick", int'(bus.elapsed_time), 4);

        // arm and abort together: abort wins
        bus.arm = 1'b1; bus.abort = 1'b1; cyc(1);
        bus.arm = 1'b0; bus.abort = 1'b0;
        seen = 0;
        repeat (40) begin
            cyc(1);
            if (bus.delay_done || bus.running) seen = 1;
        end
        check("arm_abort_idle", seen, 0);
        check("arm_abort_keeps_elapsed", int'(bus.elapsed_time), 4);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.arm         = ($urandom_range(0, 39) == 0);
            bus.abort       = ($urandom_range(0, 79) == 0);
            bus.start_timer = ($urandom_range(0, 5) == 0);
            bus.stop_timer  = ($urandom_range(0, 29) == 0);
            cyc(1);
        end
        bus.arm = 1'b0; bus.abort = 1'b0;
        bus.start_timer = 1'b0; bus.stop_timer = 1'b0;
        cyc(2);

        // asynchronous reset in the middle of a run
        pulse_arm();
        wait_done(k);
        pulse_start();
        cyc(6);
        check("pre_reset_running", int'(bus.running), 1);
        check("pre_reset_elapsed", int'(bus.elapsed_time), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_running", int'(bus.running), 0);
        check("async_rst_elapsed", int'(bus.elapsed_time), 0);
        check("async_rst_done", int'(bus.delay_done), 0);
        check("async_rst_overflow", int'(bus.overflow), 0);
        check("async_rst_lfsr", int'(u_dut.u_lfsr.lfsr_q), 32'hACE1);
        cyc(1);
        rst_n = 1'b1;
        pulse_arm();
        wait_done(k);
        check("post_reset_arm_to_done", k, 17);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/reaction_timebase.md
# reaction_timebase

Timing back-end for the reaction-time game. It answers the control FSM's requests. On `arm` it runs a pseudo-random wait and then raises `delay_done`. On `start_timer` it counts reaction time in milliseconds, and on `stop_timer` it freezes and holds the result on `elapsed_time`. It sits between the control FSM and the display/BCD path and shares the FSM's clock.

## Interface
- `TICK_DIV`, default 10000: clocks per 1 ms tick (10 MHz clock).
- `MIN_DELAY_MS`, default 1000: fixed part of the random wait, in ms.
- `RAND_BITS`, default 11: LFSR bits added to the wait (0..2047 ms).
- `MAX_COUNT`, default 9999: saturation value of `elapsed_time`.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `arm` in 1: one-cycle pulse; clear the result and start a new random wait.
- `abort` in 1: level or pulse; cancel the wait or run and return to IDLE (driven from the FSM's `show_error`).
- `start_timer` in 1: one-cycle pulse; begin reaction counting.
- `stop_timer` in 1: one-cycle pulse; freeze the count.
- `delay_done` out 1: level; the wait has expired and the block is waiting for `start_timer`.
- `elapsed_time` out 14: reaction time in ms, range 0..MAX_COUNT.
- `running` out 1: high while counting.
- `overflow` out 1: sticky; the count saturated at MAX_COUNT.

## Operation
- States: IDLE, DELAY, EXPIRED, RUN, HOLD.
- Input priority, per cycle: `abort` > `arm` > `stop_timer` > `start_timer`.
- `abort`, any state: go to IDLE, zero the delay counter, keep `elapsed_time`.
- `arm`, any state: go to DELAY.
  - Load the delay counter with MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
  - Clear `elapsed_time` and `overflow`.
  - Zero the prescaler.
- DELAY: decrement the delay counter on each ms tick. When it reaches 0, go to EXPIRED.
- EXPIRED: `delay_done` = 1. `start_timer` zeroes the prescaler and goes to RUN.
- RUN: `running` = 1. Increment `elapsed_time` on each ms tick.
  - At MAX_COUNT, hold the value and set `overflow`. Stay in RUN.
  - `stop_timer` goes to HOLD. A tick in the same cycle as `stop_timer` is not counted.
- HOLD: `elapsed_time` is frozen until the next `arm`.
- Ignored inputs:
  - `start_timer` outside EXPIRED.
  - `stop_timer` outside RUN.
  - `arm` while already in DELAY restarts the wait with a fresh random value.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Seed 16'hACE1. Advances every clock in every state.
  - Only the delay load samples it, so randomness comes from the human timing of `arm`.
- Width rules:
  - Delay counter: 12 bits; MIN_DELAY_MS + 2^RAND_BITS − 1 ≤ 4095 is a required parameter constraint.
  - Prescaler: ceil(log2(TICK_DIV)) bits.
  - `elapsed_time`: saturating, never wraps.

## Timing
- Reset values:
  - State IDLE; `delay_done`, `running`, `overflow` = 0.
  - `elapsed_time` = 0; prescaler = 0; LFSR = 16'hACE1.
- All outputs are registered. State decode is not driven combinationally to ports.
- Prescaler:
  - Ms tick is a one-cycle internal strobe when the prescaler equals TICK_DIV−1; the prescaler then wraps to 0.
  - The prescaler runs only in DELAY and RUN.
- Delay latency: `delay_done` rises exactly (delay_load × TICK_DIV) + 1 cycles after the `arm` cycle.
- `delay_done` stays high until `start_timer`, `arm` or `abort`; it falls the cycle after.
- Run latency:
  - First increment occurs TICK_DIV cycles after the `start_timer` cycle.
  - `running` rises the cycle after `start_timer` and falls the cycle after `stop_timer`.
- Reset asserted mid-operation: all registers return to reset values immediately. The first edge after deassertion behaves as IDLE.

## Structure
- Shared package `reaction_pkg`:
  - State encoding localparams.
  - LFSR seed and tap constants.
  - `MAX_COUNT` and width constants.
- Sub-module `reaction_lfsr16`: the free-running 16-bit LFSR with `clk`, `rst_n` and a 16-bit `q`.
- Prescaler, delay counter and FSM stay in the top module.
- Estimated size: about 180 lines total.

## Test plan
Simulation parameters: TICK_DIV=4, MIN_DELAY_MS=3, RAND_BITS=2.

- Reset, then `arm` at LFSR seed 16'hACE1 (lfsr[1:0]=01), giving load 4. Required: `delay_done` rises exactly 17 cycles after `arm` and stays high until `start_timer`.
- `start_timer` in EXPIRED, `stop_timer` 22 cycles later. Required: `elapsed_time`=5, `running` falls the next cycle, value is held through 50 idle cycles.
- `abort` mid-DELAY. Required: `delay_done` never asserts; state is IDLE; a later `start_timer` leaves `running`=0.
- Run with MAX_COUNT=9 for 60 cycles. Required: `elapsed_time` sticks at 9, `overflow`=1, then `arm` clears both to 0.
- `stop_timer` and a ms tick in the same cycle. Required: count is not incremented. `arm` and `abort` in the same cycle: IDLE results.
- Drop `rst_n` low mid-RUN between clock edges. Required: outputs zero immediately without waiting for a clock edge, and the LFSR reloads 16'hACE1.
